mcycle_unit: RTL and testbench

Iterative unsigned multiply/divide unit that sits directly downstream of the control unit in the ARM datapath.
- The decoder raises Start and MCycleOp for MUL/DIV instructions.
- This block holds Busy so the processor stalls its PC and register write, then returns a double-width result.
- One iteration per clock. Results are held in dedicated output registers until the next completion.

---
 rtl/mcycle_unit_if.sv | 24 ++
 rtl/mcycle_unit.sv | 119 +++++++++++
 tb/tb_mcycle_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mcycle_unit_if.sv
// Request/result bundle between the control unit and the iterative multiply/divide unit.
// The control unit uses the master modport; mcycle_unit uses the slave modport.
interface mcycle_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic             MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, Busy, Done
    );

    modport slave (
        input  Start, MCycleOp, Operand1, Operand2,
        output Result1, Result2, Busy, Done
    );
endinterface

// File: rtl/mcycle_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit, one iteration per clock.
// Busy stalls the pipeline from the issue cycle; results are held until the next completion.
module mcycle_unit #(
    parameter int WIDTH = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    mcycle_unit_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, COMPUTING} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               op;
    logic [WIDTH-1:0]   divisor;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   result1, result2;
    logic               done;

    logic               launch, finish, busy;
    logic [2*WIDTH-1:0] mul_nx;
    logic [2*WIDTH-1:0] div_nx;

    // One shift-add step: conditionally add into the upper WIDTH+1 bits, then shift right.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0]   b);
        logic [WIDTH:0]   upper;
        logic [2*WIDTH:0] wide;
        upper = {1'b0, a[2*WIDTH-1:WIDTH]} + (a[0] ? {1'b0, b} : '0);
        wide  = {upper, a[WIDTH-1:0]};
        return wide[2*WIDTH:1];
    endfunction

    // One restoring-division step; returns {remainder, quotient}.
    // The remainder always fits in WIDTH bits (it stays below the divisor, or for a zero
    // divisor it is a prefix of the dividend), so only the shifted trial needs WIDTH+1 bits.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                     input logic [WIDTH-1:0] q,
                                                     input logic [WIDTH-1:0] b);
        logic [WIDTH:0] shifted;
        shifted = {r, q[WIDTH-1]};
        if (shifted >= {1'b0, b})
            return {WIDTH'(shifted - {1'b0, b}), q[WIDTH-2:0], 1'b1};
        else
            return {shifted[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
    endfunction

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        mul_nx     = mul_step(acc, divisor);
        div_nx     = div_step(rem, acc[WIDTH-1:0], divisor);
        case (state)
            IDLE: begin
                // Start is masked while reset is asserted so no stall leaks out of reset.
                if (bus.Start && RESET) begin
                    launch     = 1'b1;
                    busy       = 1'b1;
                    state_next = COMPUTING;
                end
            end
            COMPUTING: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            cnt     <= '0;
            op      <= 1'b0;
            divisor <= '0;
            acc     <= '0;
            rem     <= '0;
            result1 <= '0;
            result2 <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_next;
            done  <= finish;
            if (launch) begin
                op      <= bus.MCycleOp;
                divisor <= bus.Operand2;
                acc     <= {{WIDTH{1'b0}}, bus.Operand1};
                rem     <= '0;
                cnt     <= '0;
            end else if (state == COMPUTING) begin
                cnt <= cnt + 1'b1;
                if (op) begin
                    rem               <= div_nx[2*WIDTH-1:WIDTH];
                    acc[WIDTH-1:0]    <= div_nx[WIDTH-1:0];
                end else begin
                    acc <= mul_nx;
                end
            end
            if (finish) begin
                result1 <= op ? div_nx[WIDTH-1:0]       : mul_nx[WIDTH-1:0];
                result2 <= op ? div_nx[2*WIDTH-1:WIDTH] : mul_nx[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign bus.Busy    = busy;
    assign bus.Done    = done;
    assign bus.Result1 = result1;
    assign bus.Result2 = result2;
endmodule

// File: tb/tb_mcycle_unit.sv
// Directed bench for mcycle_unit: reset, multiply, divide, divide-by-zero, ignored
// mid-operation requests, back-to-back launch and asynchronous abort.
module tb_mcycle_unit;
    localparam int WIDTH = 32;

    logic CLK = 1'b0;
    logic RESET;
    int   total = 0;
    int   bad   = 0;

    mcycle_unit_if #(.WIDTH(WIDTH)) ifc ();

    mcycle_unit #(.WIDTH(WIDTH)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (ifc.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one operation and follow it to completion. With b2b set the launch happens
    // in the current (Done) cycle instead of after the next falling edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic opc,
                          input logic [31:0] e1, input logic [31:0] e2, input string tag,
                          input bit b2b, input bit disturb, input bit tail);
        logic [31:0] r1_old, r2_old;
        int          n;
        bit          hold_ok;
        if (!b2b) @(negedge CLK);
        r1_old = ifc.Result1;
        r2_old = ifc.Result2;
        ifc.Operand1 = a;
        ifc.Operand2 = b;
        ifc.MCycleOp = opc;
        ifc.Start    = 1'b1;
        n       = 0;
        hold_ok = 1'b1;
        #1;
        chk({tag, "_busy_issue"}, {63'd0, ifc.Busy}, 64'd1);
        while (ifc.Busy === 1'b1 && n < 100) begin
            n++;
            if (ifc.Result1 !== r1_old || ifc.Result2 !== r2_old) hold_ok = 1'b0;
            @(negedge CLK);
            ifc.Start = disturb && (n == 5);
            if (disturb && n == 5) begin
                ifc.Operand1 = 32'hDEADBEEF;
                ifc.Operand2 = 32'd3;
                ifc.MCycleOp = ~opc;
            end
            #1;
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'd33);
        chk({tag, "_hold"}, {63'd0, hold_ok}, 64'd1);
        chk({tag, "_done"}, {63'd0, ifc.Done}, 64'd1);
        chk({tag, "_r1"}, {32'd0, ifc.Result1}, {32'd0, e1});
        chk({tag, "_r2"}, {32'd0, ifc.Result2}, {32'd0, e2});
        if (tail) begin
            @(negedge CLK);
            #1;
            chk({tag, "_done_drop"}, {63'd0, ifc.Done}, 64'd0);
            chk({tag, "_r1_stable"}, {32'd0, ifc.Result1}, {32'd0, e1});
        end
    endtask

    initial begin
        bit done_seen;
        RESET        = 1'b0;
        ifc.Start    = 1'b0;
        ifc.MCycleOp = 1'b0;
        ifc.Operand1 = '0;
        ifc.Operand2 = '0;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_busy", {63'd0, ifc.Busy}, 64'd0);
        chk("rst_done", {63'd0, ifc.Done}, 64'd0);
        chk("rst_r1", {32'd0, ifc.Result1}, 64'd0);
        chk("rst_r2", {32'd0, ifc.Result2}, 64'd0);
        @(negedge CLK);
        RESET = 1'b1;

        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000001, 32'hFFFFFFFE, "mul_max", 0, 0, 1);
        run_op(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, "div_100_7", 0, 0, 1);
        run_op(32'h12345678, 32'd0, 1'b1, 32'hFFFFFFFF, 32'h12345678, "div_zero", 0, 0, 1);
        run_op(32'd1000, 32'd10, 1'b1, 32'd100, 32'd0, "div_disturb", 0, 1, 0);
        run_op(32'd6, 32'd7, 1'b0, 32'd42, 32'd0, "mul_b2b", 1, 0, 1);

        // Abort a multiply with an asynchronous reset after ten busy cycles.
        @(negedge CLK);
        ifc.Operand1 = 32'd3;
        ifc.Operand2 = 32'd5;
        ifc.MCycleOp = 1'b0;
        ifc.Start    = 1'b1;
        repeat (10) begin
            @(negedge CLK);
            ifc.Start = 1'b0;
        end
        #1;
        chk("abort_busy_before", {63'd0, ifc.Busy}, 64'd1);
        RESET = 1'b0;
        #1;
        chk("abort_busy", {63'd0, ifc.Busy}, 64'd0);
        chk("abort_done", {63'd0, ifc.Done}, 64'd0);
        chk("abort_r1", {32'd0, ifc.Result1}, 64'd0);
        chk("abort_r2", {32'd0, ifc.Result2}, 64'd0);
        ifc.Start = 1'b1;
        #1;
        chk("abort_start_masked", {63'd0, ifc.Busy}, 64'd0);
        ifc.Start = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge CLK);
            if (ifc.Done !== 1'b0) done_seen = 1'b1;
        end
        chk("abort_no_done", {63'd0, done_seen}, 64'd0);

        run_op(32'd123, 32'd456, 1'b0, 32'd56088, 32'd0, "mul_after_rst", 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
